rsa_modexp_core: RTL and testbench

- Parametrised modular exponentiation engine: computes result = base^exponent mod modulus.
- Successor to the fixed-width encrypt/decrypt datapath, with:
  - a start/ready/done handshake,
  - operand capture,
  - error detection,
  - a registered, held result.
- Sits between the RFID tag command controller and the key/modulus store; one instance serves both encrypt (public exponent) and decrypt (private exponent).

---
 rtl/rsa_modexp_core_if.sv | 24 ++
 rtl/rsa_modexp_core.sv | 142 ++++++++++++++
 tb/tb_rsa_modexp_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_core_if.sv
// Handshake and operand bundle for rsa_modexp_core; WordSize must match the core.
interface rsa_modexp_core_if #(
  parameter int WordSize = 8
);
  logic                start;
  logic [WordSize-1:0] base;
  logic [WordSize-1:0] exponent;
  logic [WordSize-1:0] modulus;
  logic                ready;
  logic                busy;
  logic                done;
  logic                err;
  logic [WordSize-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  ready, busy, done, err, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output ready, busy, done, err, result
  );
endinterface

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation (LSB-first square-and-multiply, shift-add modular multiplier).
// RSA_CONST_TIME_EN: run MUL on every exponent bit so latency is exponent-independent.
module rsa_modexp_core #(
  parameter int WordSize = 8
) (
  input logic              clk,
  input logic              reset,
  rsa_modexp_core_if.slave bus
);
  localparam int IW = $clog2(WordSize + 1);
  localparam logic [IW-1:0] IDX_END  = IW'(WordSize);
  localparam logic [IW-1:0] CNT_LAST = IW'(WordSize - 1);
  localparam logic [WordSize-1:0] ONE = WordSize'(1);

  // NEXT is not a register state: it is the branch taken on the last LOAD/MUL/SQR cycle.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] SQR  = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  logic [2:0]          state;
  logic [WordSize-1:0] b_q, e_q, m_q;
  logic [WordSize-1:0] acc, sq, p;
  logic [WordSize-1:0] result_q;
  logic [IW-1:0]       idx, cnt;
  logic                err_pend, err_q, done_q;

  logic [WordSize-1:0] mul_a;
  logic [WordSize:0]   m_ext, p_dbl, p_add;
  logic                mul_bit, last;
  logic [IW-1:0]       branch_idx;
  logic [2:0]          branch_state;
`ifdef RSA_CONST_TIME_EN
  logic                cur_bit;
`else
  logic                branch_bit;
`endif

  always_comb begin
    m_ext   = {1'b0, m_q};
    mul_a   = (state == MUL) ? acc : sq;
    mul_bit = |(mul_a & (ONE << (CNT_LAST - cnt)));
    last    = (cnt == CNT_LAST);
    p_dbl   = {p, 1'b0};
    if (p_dbl >= m_ext) p_dbl = p_dbl - m_ext;
    p_add = p_dbl;
    if (mul_bit) begin
      p_add = p_dbl + {1'b0, sq};
      if (p_add >= m_ext) p_add = p_add - m_ext;
    end
    branch_idx = (state == SQR) ? idx + 1'b1 : '0;
`ifdef RSA_CONST_TIME_EN
    cur_bit = |(e_q & (ONE << idx));
    branch_state = (branch_idx == IDX_END) ? FIN : MUL;
`else
    branch_bit = |(e_q & (ONE << branch_idx));
    if (branch_idx == IDX_END) branch_state = FIN;
    else if (branch_bit)       branch_state = MUL;
    else                       branch_state = SQR;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      b_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      sq       <= '0;
      p        <= '0;
      idx      <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle already shows ready, but start is only taken one cycle later.
          if (bus.start && !done_q) begin
            b_q   <= bus.base;
            e_q   <= bus.exponent;
            m_q   <= bus.modulus;
            state <= LOAD;
          end
        end
        LOAD: begin
          p   <= '0;
          cnt <= '0;
          idx <= '0;
          if (m_q < WordSize'(2) || b_q >= m_q) begin
            err_pend <= 1'b1;
            state    <= FIN;
          end else begin
            err_pend <= 1'b0;
            acc      <= ONE;
            sq       <= b_q;
            state    <= branch_state;
          end
        end
        MUL, SQR: begin
          if (last) begin
            p   <= '0;
            cnt <= '0;
            if (state == MUL) begin
`ifdef RSA_CONST_TIME_EN
              if (cur_bit) acc <= p_add[WordSize-1:0];
`else
              acc <= p_add[WordSize-1:0];
`endif
              state <= SQR;
            end else begin
              sq    <= p_add[WordSize-1:0];
              idx   <= branch_idx;
              state <= branch_state;
            end
          end else begin
            p   <= p_add[WordSize-1:0];
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          result_q <= err_pend ? '0 : acc;
          err_q    <= err_pend;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Randomised and directed checks of rsa_modexp_core against an arithmetic reference model.
module tb_rsa_modexp_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ndone = 0;

  always #5 clk = ~clk;

  rsa_modexp_core_if #(.WordSize(8))  bus8 ();
  rsa_modexp_core_if #(.WordSize(16)) bus16 ();

  rsa_modexp_core #(.WordSize(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  rsa_modexp_core #(.WordSize(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned e,
                                             input longint unsigned m, input int w);
    longint unsigned r = 1, s = b % m;
    for (int i = 0; i < w; i++) begin
      if (e[i]) r = (r * s) % m;
      s = (s * s) % m;
    end
    return r;
  endfunction

  function automatic bit is_legal(input longint unsigned b, input longint unsigned m);
    return (m >= 2) && (b < m);
  endfunction

  function automatic int lat(input longint unsigned e, input int w, input bit errpath);
    if (errpath) return 2;
`ifdef RSA_CONST_TIME_EN
    return 2 + 2 * w * w;
`else
    return 2 + w * (w + $countones(e));
`endif
  endfunction

  // Transaction-level model of the 8-bit instance: a countdown per accepted request.
  logic       m_busy, m_done, m_err, p_err;
  logic [7:0] m_result, p_result;
  int         m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_result <= '0;
      m_cnt <= 0; p_err <= 1'b0; p_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_result <= p_result; m_err <= p_err;
        end
        m_cnt <= m_cnt - 1;
      end else if (bus8.start && !m_done) begin
        p_err    <= !is_legal(bus8.base, bus8.modulus);
        p_result <= is_legal(bus8.base, bus8.modulus) ?
                    8'(modexp(bus8.base, bus8.exponent, bus8.modulus, 8)) : 8'd0;
        m_cnt    <= lat(bus8.exponent, 8, !is_legal(bus8.base, bus8.modulus));
        m_busy   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cycle_outputs", {bus8.ready, bus8.busy, bus8.done, bus8.err, bus8.result},
            {!m_busy, m_busy, m_done, m_err, m_result});
      if (bus8.done) ndone++;
    end
  end

  task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                      input logic [7:0] xr, input logic xe, input int xl, input string nm);
    int n = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.base = b; bus8.exponent = e; bus8.modulus = m;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.base = 8'($urandom); bus8.exponent = 8'($urandom); bus8.modulus = 8'($urandom);
    while (bus8.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, xl);
    check({nm, "_result"}, bus8.result, xr);
    check({nm, "_err"}, bus8.err, xe);
  endtask

  task automatic run16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       input logic [15:0] xr, input int xl, input string nm);
    int n = 0;
    @(negedge clk);
    bus16.start = 1'b1; bus16.base = b; bus16.exponent = e; bus16.modulus = m;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0; bus16.base = 16'($urandom); bus16.modulus = 16'($urandom);
    while (bus16.done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, xl);
    check({nm, "_result"}, bus16.result, xr);
    check({nm, "_err"}, bus16.err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    logic [7:0] b, e, m;
    bus8.start = 1'b0;  bus8.base = '0;  bus8.exponent = '0;  bus8.modulus = '0;
    bus16.start = 1'b0; bus16.base = '0; bus16.exponent = '0; bus16.modulus = '0;

    // Hand-computed values pin the reference model.
    check("model_enc", modexp(7, 3, 33, 8), 13);
    check("model_dec", modexp(13, 7, 33, 8), 7);
    check("model_wide", modexp(4, 13, 497, 16), 445);
    check("model_exp0", modexp(5, 0, 33, 8), 1);
`ifdef RSA_CONST_TIME_EN
    check("lat_enc", lat(3, 8, 0), 130);
    check("lat_dec", lat(7, 8, 0), 130);
`else
    check("lat_enc", lat(3, 8, 0), 82);
    check("lat_dec", lat(7, 8, 0), 90);
`endif

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {bus8.ready, bus8.busy, bus8.done, bus8.err, bus8.result}, 12'h800);
    reset = 1'b0;

    run8(7, 3, 33, 13, 1'b0, lat(3, 8, 0), "encrypt");
    run8(13, 7, 33, 7, 1'b0, lat(7, 8, 0), "decrypt");
    run8(5, 0, 33, 1, 1'b0, lat(0, 8, 0), "exp_zero");
    run8(5, 3, 1, 0, 1'b1, 2, "err_mod1");
    run8(40, 3, 33, 0, 1'b1, 2, "err_base");
    run8(7, 3, 33, 13, 1'b0, lat(3, 8, 0), "err_cleared");

    run16(4, 13, 497, 445, lat(13, 16, 0), "wide");
    run16(5, 0, 33, 1, lat(0, 16, 0), "wide_exp0");

    // Second start and changed operands while busy must be ignored.
    n0 = ndone;
    @(negedge clk);
    bus8.start = 1'b1; bus8.base = 7; bus8.exponent = 3; bus8.modulus = 33;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (10) @(negedge clk);
    bus8.start = 1'b1; bus8.base = 13; bus8.exponent = 7; bus8.modulus = 33;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (300) @(negedge clk);
    check("busy_ignore_dones", ndone - n0, 1);
    check("busy_ignore_result", bus8.result, 13);

    // Start held high: back-to-back operations, timing checked cycle by cycle.
    n0 = ndone;
    n = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.base = 13; bus8.exponent = 7; bus8.modulus = 33;
    while (ndone - n0 < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    check("held_start_dones", ndone - n0, 3);
    check("held_start_result", bus8.result, 7);

    for (int i = 0; i < 25; i++) begin
      m = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = 8'($urandom);
      if (m >= 2 && ($urandom % 4) != 0) b = 8'($urandom % m);
      run8(b, e, m, is_legal(b, m) ? 8'(modexp(b, e, m, 8)) : 8'd0, !is_legal(b, m),
           lat(e, 8, !is_legal(b, m)), "random");
    end

    // Reset pulse while the engine is multiplying.
    @(negedge clk);
    bus8.start = 1'b1; bus8.base = 13; bus8.exponent = 7; bus8.modulus = 33;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", bus8.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", {bus8.ready, bus8.busy, bus8.done, bus8.err, bus8.result}, 12'h800);
    @(negedge clk);
    reset = 1'b0;
    n0 = ndone;
    repeat (150) @(negedge clk);
    check("no_done_after_reset", ndone - n0, 0);
    run8(13, 7, 33, 7, 1'b0, lat(7, 8, 0), "after_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
